game_referee: RTL and testbench

- Referee and score keeper for the volleyball match; sits directly downstream of the ball block.
- Watches Ball_X/Ball_Y for floor contact and awards the point to the correct side.
- Drives Game_state and who_win back into the ball block, which uses them to re-serve the ball.
- Score outputs feed the display/renderer.

---
 rtl/pika_pkg.sv | 23 ++
 rtl/btn_edge_sync.sv | 31 +++
 rtl/game_referee.sv | 113 +++++++++++
 tb/tb_game_referee.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pika_pkg.sv
// Shared definitions for the volleyball game: state encodings and screen/court geometry.
`default_nettype none

package pika_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GAME  = 2'd2,
    ST_END   = 2'd3
  } game_state_t;

  localparam int BALL_W    = 30;
  localparam int BALL_H    = 30;
  localparam int VBUF_W    = 320;
  localparam int VBUF_H    = 240;
  localparam int NET_POS_X = 160;
  localparam int NET_W     = 6;
  localparam int FLOOR_Y   = 220;

endpackage

`default_nettype wire

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for an asynchronous button followed by a one-cycle rising-edge pulse.
`default_nettype none

module btn_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic rise
);

  logic meta;
  logic sync;
  logic hist;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
      hist <= sync;
    end
  end

  assign rise = sync & ~hist;

endmodule

`default_nettype wire

// File: rtl/game_referee.sv
// Volleyball referee: detects floor contact, awards points, sequences START/WAIT/GAME/END.
`default_nettype none

module game_referee #(
  parameter int BALL_W         = pika_pkg::BALL_W,
  parameter int BALL_H         = pika_pkg::BALL_H,
  parameter int FLOOR_Y        = pika_pkg::FLOOR_Y,
  parameter int NET_POS_X      = pika_pkg::NET_POS_X,
  parameter int NET_W          = pika_pkg::NET_W,
  parameter int PLAYER_ON_LEFT = 1,
  parameter int WAIT_CYCLES    = 100_000_000,
  parameter int WIN_SCORE      = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_btn,
  input  logic [11:0] Ball_X,
  input  logic [11:0] Ball_Y,
  output logic [1:0]  Game_state,
  output logic        who_win,
  output logic [3:0]  player_score,
  output logic [3:0]  npc_score,
  output logic        point_pulse
);

  import pika_pkg::*;

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  game_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             start_rise;
  logic [12:0]      ball_bottom;
  logic [12:0]      ball_cx;
  logic             landed;
  logic             on_left;
  logic             npc_gets;
  logic [3:0]       npc_next;
  logic [3:0]       player_next;

  btn_edge_sync u_start_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (start_btn),
    .rise    (start_rise)
  );

  // 13-bit arithmetic keeps the sums from wrapping near the top of the 12-bit range.
  assign ball_bottom = {1'b0, Ball_Y} + 13'(BALL_H);
  assign ball_cx     = {1'b0, Ball_X} + 13'(BALL_W / 2);
  assign landed      = (ball_bottom >= 13'(FLOOR_Y));
  assign on_left     = (ball_cx < 13'(NET_POS_X + NET_W / 2));
  assign npc_gets    = (PLAYER_ON_LEFT != 0) ? on_left : ~on_left;
  assign npc_next    = npc_score + 4'd1;
  assign player_next = player_score + 4'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_START;
      cnt          <= '0;
      who_win      <= 1'b0;
      player_score <= 4'd0;
      npc_score    <= 4'd0;
      point_pulse  <= 1'b0;
    end else begin
      point_pulse <= 1'b0;
      case (state)
        ST_START: begin
          if (start_rise) begin
            player_score <= 4'd0;
            npc_score    <= 4'd0;
            who_win      <= 1'b0;
            cnt          <= '0;
            state        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == CNT_W'(WAIT_CYCLES - 1)) begin
            cnt   <= '0;
            state <= ST_GAME;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAME: begin
          // Leaving IN_GAME on the scoring edge guarantees one point per rally.
          if (landed) begin
            point_pulse <= 1'b1;
            cnt         <= '0;
            if (npc_gets) begin
              npc_score <= npc_next;
              who_win   <= 1'b1;
              state     <= (npc_next == 4'(WIN_SCORE)) ? ST_END : ST_WAIT;
            end else begin
              player_score <= player_next;
              who_win      <= 1'b0;
              state        <= (player_next == 4'(WIN_SCORE)) ? ST_END : ST_WAIT;
            end
          end
        end
        ST_END: begin
          if (start_rise) state <= ST_START;
        end
        default: state <= ST_START;
      endcase
    end
  end

  assign Game_state = state;

endmodule

`default_nettype wire

// File: tb/tb_game_referee.sv
// Scoreboard bench for game_referee with a short wait and a 3-point game.
`default_nettype none

module tb_game_referee;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_btn;
  logic [11:0] Ball_X;
  logic [11:0] Ball_Y;
  logic [1:0]  Game_state;
  logic        who_win;
  logic [3:0]  player_score;
  logic [3:0]  npc_score;
  logic        point_pulse;

  always #5 clk = ~clk;

  game_referee #(
    .PLAYER_ON_LEFT (1),
    .WAIT_CYCLES    (4),
    .WIN_SCORE      (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_btn    (start_btn),
    .Ball_X       (Ball_X),
    .Ball_Y       (Ball_Y),
    .Game_state   (Game_state),
    .who_win      (who_win),
    .player_score (player_score),
    .npc_score    (npc_score),
    .point_pulse  (point_pulse)
  );

  typedef struct packed {
    logic [1:0] st;
    logic       who;
    logic [3:0] ps;
    logic [3:0] ns;
    logic       pulse;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   step         = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s (step %0d): got %0d expected %0d", tag, step, obs, exp);
    end
  endtask

  // Push the expectation for the coming edge, then compare once the edge has settled.
  task automatic cyc(input logic [1:0] st, input logic who, input logic [3:0] ps,
                     input logic [3:0] ns, input logic pulse);
    exp_t e;
    sb_q.push_back(exp_t'{st, who, ps, ns, pulse});
    @(posedge clk);
    #1;
    step++;
    e = sb_q.pop_front();
    check("Game_state",   32'(Game_state),   32'(e.st));
    check("who_win",      32'(who_win),      32'(e.who));
    check("player_score", 32'(player_score), 32'(e.ps));
    check("npc_score",    32'(npc_score),    32'(e.ns));
    check("point_pulse",  32'(point_pulse),  32'(e.pulse));
  endtask

  task automatic wait_drop(input logic who, input logic [3:0] ps, input logic [3:0] ns);
    repeat (3) cyc(2'd1, who, ps, ns, 1'b0);
    cyc(2'd2, who, ps, ns, 1'b0);
  endtask

  initial begin
    reset_n   = 1'b0;
    start_btn = 1'b0;
    Ball_X    = 12'd80;
    Ball_Y    = 12'd0;
    cyc(2'd0, 0, 4'd0, 4'd0, 0);
    cyc(2'd0, 0, 4'd0, 4'd0, 0);
    reset_n = 1'b1;
    cyc(2'd0, 0, 4'd0, 4'd0, 0);

    // Start press held across the START->WAIT transition: exactly one rise.
    start_btn = 1'b1;
    cyc(2'd0, 0, 4'd0, 4'd0, 0);
    cyc(2'd0, 0, 4'd0, 4'd0, 0);
    cyc(2'd1, 0, 4'd0, 4'd0, 0);
    wait_drop(0, 4'd0, 4'd0);
    start_btn = 1'b0;

    // NPC point on the left (player) court.
    Ball_X = 12'd40; Ball_Y = 12'd190;
    cyc(2'd1, 1, 4'd0, 4'd1, 1);
    Ball_Y = 12'd0;
    wait_drop(1, 4'd0, 4'd1);

    // Player point with a start rise arriving on the landing edge.
    Ball_X = 12'd250; start_btn = 1'b1;
    cyc(2'd2, 1, 4'd0, 4'd1, 0);
    cyc(2'd2, 1, 4'd0, 4'd1, 0);
    Ball_Y = 12'd200;
    cyc(2'd1, 0, 4'd1, 4'd1, 1);
    start_btn = 1'b0; Ball_Y = 12'd0;
    wait_drop(0, 4'd1, 4'd1);

    // One pixel above the floor: no landing.
    Ball_Y = 12'd189;
    cyc(2'd2, 0, 4'd1, 4'd1, 0);
    cyc(2'd2, 0, 4'd1, 4'd1, 0);

    // Court split boundary: cx=163 is right court, cx=162 is left court.
    Ball_X = 12'd148; Ball_Y = 12'd190;
    cyc(2'd1, 0, 4'd2, 4'd1, 1);
    Ball_Y = 12'd0;
    wait_drop(0, 4'd2, 4'd1);
    Ball_X = 12'd147; Ball_Y = 12'd190;
    cyc(2'd1, 1, 4'd2, 4'd2, 1);
    Ball_Y = 12'd0;
    wait_drop(1, 4'd2, 4'd2);

    // Winning point, then held landings leave everything frozen.
    Ball_X = 12'd40; Ball_Y = 12'd190;
    cyc(2'd3, 1, 4'd2, 4'd3, 1);
    cyc(2'd3, 1, 4'd2, 4'd3, 0);
    Ball_X = 12'd250;
    cyc(2'd3, 1, 4'd2, 4'd3, 0);
    Ball_X = 12'd40;

    // GAME_END -> START keeps scores until START is exited.
    start_btn = 1'b1;
    cyc(2'd3, 1, 4'd2, 4'd3, 0);
    cyc(2'd3, 1, 4'd2, 4'd3, 0);
    cyc(2'd0, 1, 4'd2, 4'd3, 0);
    start_btn = 1'b0;
    cyc(2'd0, 1, 4'd2, 4'd3, 0);
    cyc(2'd0, 1, 4'd2, 4'd3, 0);

    // New game clears scores; reset during WAIT with a landing present.
    start_btn = 1'b1;
    cyc(2'd0, 1, 4'd2, 4'd3, 0);
    cyc(2'd0, 1, 4'd2, 4'd3, 0);
    cyc(2'd1, 0, 4'd0, 4'd0, 0);
    start_btn = 1'b0;
    cyc(2'd1, 0, 4'd0, 4'd0, 0);
    reset_n = 1'b0;
    cyc(2'd0, 0, 4'd0, 4'd0, 0);
    reset_n = 1'b1;
    cyc(2'd0, 0, 4'd0, 4'd0, 0);
    cyc(2'd0, 0, 4'd0, 4'd0, 0);
    Ball_Y = 12'd0;

    // Fresh game won by three NPC landings.
    start_btn = 1'b1;
    cyc(2'd0, 0, 4'd0, 4'd0, 0);
    cyc(2'd0, 0, 4'd0, 4'd0, 0);
    cyc(2'd1, 0, 4'd0, 4'd0, 0);
    start_btn = 1'b0;
    wait_drop(0, 4'd0, 4'd0);
    for (int i = 1; i <= 3; i++) begin
      Ball_X = 12'd40; Ball_Y = 12'd190;
      if (i < 3) begin
        cyc(2'd1, 1, 4'd0, 4'(i), 1);
        Ball_Y = 12'd0;
        wait_drop(1, 4'd0, 4'(i));
      end else begin
        cyc(2'd3, 1, 4'd0, 4'd3, 1);
      end
    end
    cyc(2'd3, 1, 4'd0, 4'd3, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
